// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects raw push-button
// levels. Each channel has its own 2-flop synchronizer, a debounce counter, a
// registered stable level and single-cycle press/release pulses.
// Optional long-press detection is compiled in with `define BUTTON_LONG_PRESS_EN;
// without it long_pulse is tied low and no hold counters exist.
module button_conditioner #(
    parameter int CHANNELS        = 3,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int LONG_CYCLES     = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);

    // Counter reaches DEBOUNCE_CYCLES-1 on the last agreeing sample; a single
    // bit is kept even when DEBOUNCE_CYCLES is 1 so the compare stays legal.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_LONG_PRESS_EN
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    // Value the hold counter holds on the edge before it first saturates.
    localparam logic [HOLD_W-1:0] HOLD_ARM  = HOLD_W'(LONG_CYCLES - 2);
`endif

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic             press_reg;
            logic             release_reg;
            logic [CNT_W-1:0] cnt_reg;

            // Synchronize the pin, then accept a new level only after it has
            // differed from the stable level for DEBOUNCE_CYCLES straight edges.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    stable_reg  <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= btn_raw[gi];
                    sync2_reg   <= sync1_reg;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    if (sync2_reg == stable_reg) begin
                        // Any sample matching the stable level restarts the count.
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        stable_reg  <= sync2_reg;
                        cnt_reg     <= '0;
                        press_reg   <= sync2_reg;
                        release_reg <= ~sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign btn_level[gi]     = stable_reg;
            assign press_pulse[gi]   = press_reg;
            assign release_pulse[gi] = release_reg;

`ifdef BUTTON_LONG_PRESS_EN
            logic [HOLD_W-1:0] hold_reg;
            logic              long_reg;

            // Count edges of continuous debounced press; pulse once when the
            // count first saturates. Saturation holds it quiet until release.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hold_reg <= '0;
                    long_reg <= 1'b0;
                end else if (!stable_reg) begin
                    hold_reg <= '0;
                    long_reg <= 1'b0;
                end else if (hold_reg != HOLD_LAST) begin
                    hold_reg <= hold_reg + 1'b1;
                    long_reg <= (hold_reg == HOLD_ARM);
                end else begin
                    long_reg <= 1'b0;
                end
            end

            assign long_pulse[gi] = long_reg;
`else
            // Long-press detection compiled out: output is constant low
            // (LONG_CYCLES is a positive count, so the compare is always false).
            assign long_pulse[gi] = (LONG_CYCLES < 0);
`endif
        end
    endgenerate

endmodule
